// File: rtl/permute_gather_pipe.sv
//------------------------------------------------------------------------------
// Module   : permute_gather_pipe
// Brief    : Lane gather (out[j] = bank[sel[j]]) behind a bank read latency,
//            buffered in a credit-protected output FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module permute_gather_pipe #(
    parameter int N      = 4,
    parameter int W      = 32,
    parameter int SELW   = 2,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*SELW-1:0] sel_bus,
    output logic              rd_en,
    input  logic [N*W-1:0]    bank_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*W-1:0]    out_bus,
    output logic [N-1:0]      oor_mask,
    output logic              busy
);

    localparam int c_log2n = $clog2(N);
    localparam int c_pw    = $clog2(DEPTH);
    localparam int c_cw    = c_pw + 1;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

    logic                 w_accept;
    logic                 w_arrive;
    logic                 w_pop;
    logic [c_cw:0]        w_pending;
    logic [W-1:0]         w_bank [N];
    logic [N*W-1:0]       w_gather;
    logic [N-1:0]         w_oor;

    logic [RD_LAT-1:0]    r_dl_vld;
    logic [N*SELW-1:0]    r_dl_sel [RD_LAT];
    logic [N*W-1:0]       r_mem_data [DEPTH];
    logic [N-1:0]         r_mem_oor [DEPTH];
    logic [c_pw-1:0]      r_wptr;
    logic [c_pw-1:0]      r_rptr;
    logic [c_cw-1:0]      r_count;
    logic [c_cw-1:0]      r_inflight;

    // Credits cover both in-flight reads and buffered words, so an accepted
    // request always has a FIFO slot waiting when its bank data returns.
    assign w_pending = {1'b0, r_inflight} + {1'b0, r_count};
    assign in_ready  = (w_pending < c_depth);
    assign w_accept  = in_valid & in_ready;
    assign rd_en     = w_accept;
    assign w_arrive  = r_dl_vld[RD_LAT-1];
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    assign busy      = (w_pending != '0);
    assign out_bus   = out_valid ? r_mem_data[r_rptr] : '0;
    assign oor_mask  = out_valid ? r_mem_oor[r_rptr] : '0;

    for (genvar b = 0; b < N; b++) begin : g_bank
        assign w_bank[b] = bank_rdata[b*W +: W];
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [SELW-1:0] w_sel;
        assign w_sel = r_dl_sel[RD_LAT-1][j*SELW +: SELW];
        // Any set bit above the bank index makes the select out of range.
        if (SELW > c_log2n) begin : g_oor
            assign w_oor[j] = |w_sel[SELW-1:c_log2n];
        end else begin : g_no_oor
            assign w_oor[j] = 1'b0;
        end
        assign w_gather[j*W +: W] = w_oor[j] ? '0 : w_bank[w_sel[c_log2n-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_vld   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            r_dl_vld[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
            end
            r_inflight <= r_inflight + c_cw'(w_accept) - c_cw'(w_arrive);
            r_count    <= r_count + c_cw'(w_arrive) - c_cw'(w_pop);
            if (w_arrive) begin
                r_wptr <= r_wptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_pw'(1);
            end
        end
    end

    // Select map and FIFO storage carry no reset; the valids above gate them.
    always_ff @(posedge clk) begin
        r_dl_sel[0] <= sel_bus;
        for (int i = 1; i < RD_LAT; i++) begin
            r_dl_sel[i] <= r_dl_sel[i-1];
        end
        if (w_arrive) begin
            r_mem_data[r_wptr] <= w_gather;
            r_mem_oor[r_wptr]  <= w_oor;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_arrive && !w_pop && (r_count == c_cw'(DEPTH))));

endmodule

`default_nettype wire
